// File: rtl/cordic_out_serializer_if.sv
// rtl/cordic_out_serializer_if.sv - narrow beat bus between serializer and sink
interface cordic_out_serializer_if #(
    parameter int BEAT_WIDTH = 8
);
    logic                  o_beat_vld;
    logic [BEAT_WIDTH-1:0] o_beat_data;
    logic                  o_beat_last;
    logic                  i_beat_rdy;

    // Serializer side drives the beat, sink side drives ready
    modport master (
        output o_beat_vld,
        output o_beat_data,
        output o_beat_last,
        input  i_beat_rdy
    );

    modport slave (
        input  o_beat_vld,
        input  o_beat_data,
        input  o_beat_last,
        output i_beat_rdy
    );
endinterface

// File: rtl/cordic_out_serializer.sv
// rtl/cordic_out_serializer.sv - result word FIFO plus MSB-first beat serializer
module cordic_out_serializer #(
    parameter int DATA_WIDTH = 56,
    parameter int BEAT_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_async_rst_n,
    input  logic                          i_vld,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_clr_ovf,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    cordic_out_serializer_if.master       beat
);
    localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         count;
    logic [0:0]            state;
    logic [BCW-1:0]        beat_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  overflow;

    logic full;
    logic push;
    logic pop;
    logic xfer;
    logic at_last;

    // Full is taken from the count register, so a same-cycle pop never rescues a write
    assign full    = (count == LW'(FIFO_DEPTH));
    assign push    = i_vld & ~full;
    assign xfer    = (state == ST_SHIFT) & beat.i_beat_rdy;
    assign at_last = (beat_cnt == BCW'(BEATS - 1));
    // Pop when idle, or chain straight into the next word on the final beat
    assign pop     = (count != '0) & ((state == ST_IDLE) | (xfer & at_last));

    // Storage array carries no reset; only pointers and count define its contents
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // FIFO bookkeeping, serializer FSM and sticky overflow
    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= ST_IDLE;
            beat_cnt <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + LW'(1);
            end else if (pop && !push) begin
                count <= count - LW'(1);
            end

            if (pop) begin
                shreg    <= mem[rd_ptr];
                beat_cnt <= '0;
                state    <= ST_SHIFT;
            end else if (xfer) begin
                // Shifting out leaves zeros behind, so the idle beat bus reads 0
                shreg    <= shreg << BEAT_WIDTH;
                beat_cnt <= beat_cnt + BCW'(1);
                if (at_last) begin
                    state <= ST_IDLE;
                end
            end

            if (i_vld && full) begin
                overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign o_full           = full;
    assign o_level          = count;
    assign o_overflow       = overflow;
    assign beat.o_beat_vld  = (state == ST_SHIFT);
    assign beat.o_beat_data = shreg[DATA_WIDTH-1 -: BEAT_WIDTH];
    assign beat.o_beat_last = (state == ST_SHIFT) & at_last;
endmodule

// File: tb/tb_cordic_out_serializer.sv
// tb/tb_cordic_out_serializer.sv - directed self-checking bench for cordic_out_serializer
module tb_cordic_out_serializer;
    logic        i_clk = 1'b0;
    logic        i_async_rst_n;
    logic        i_vld;
    logic [55:0] i_data;
    logic        i_clr_ovf;
    logic        o_full;
    logic [2:0]  o_level;
    logic        o_overflow;

    int checks   = 0;
    int failures = 0;

    cordic_out_serializer_if #(.BEAT_WIDTH(8)) bif ();

    cordic_out_serializer #(
        .DATA_WIDTH(56),
        .BEAT_WIDTH(8),
        .FIFO_DEPTH(4)
    ) dut (
        .i_clk         (i_clk),
        .i_async_rst_n (i_async_rst_n),
        .i_vld         (i_vld),
        .i_data        (i_data),
        .i_clr_ovf     (i_clr_ovf),
        .o_full        (o_full),
        .o_level       (o_level),
        .o_overflow    (o_overflow),
        .beat          (bif)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [7:0] beat_of(input logic [55:0] w, input int k);
        logic [55:0] s;
        s = w >> (8 * (6 - k));
        return s[7:0];
    endfunction

    task automatic push(input logic [55:0] w);
        i_vld  = 1'b1;
        i_data = w;
        step();
        i_vld  = 1'b0;
    endtask

    // Collect one word; bp selects a 1,0,0 ready pattern, each cycle checks the held beat
    task automatic recv_word(input logic [55:0] w, input bit bp, input string tag);
        int   k;
        int   guard;
        int   ph;
        logic r;
        k = 0;
        guard = 0;
        ph = 0;
        while (k < 7 && guard < 100) begin
            r = bp ? (ph % 3 == 0) : 1'b1;
            bif.i_beat_rdy = r;
            if (bif.o_beat_vld) begin
                chk({tag, "_data"}, 64'(bif.o_beat_data), 64'(beat_of(w, k)));
                chk({tag, "_last"}, 64'(bif.o_beat_last), 64'(k == 6));
                if (r) k++;
                ph++;
            end
            step();
            guard++;
        end
        if (k != 7) chk({tag, "_timeout"}, 64'(k), 64'd7);
    endtask

    initial begin
        logic [55:0] wq[$];
        logic [55:0] ws[5];
        logic [7:0]  b;
        int          sent;
        int          got;
        int          kb;

        i_async_rst_n  = 1'b0;
        i_vld          = 1'b0;
        i_data         = '0;
        i_clr_ovf      = 1'b0;
        bif.i_beat_rdy = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_vld",   64'(bif.o_beat_vld),  64'd0);
        chk("rst_data",  64'(bif.o_beat_data), 64'd0);
        chk("rst_last",  64'(bif.o_beat_last), 64'd0);
        chk("rst_full",  64'(o_full),          64'd0);
        chk("rst_level", 64'(o_level),         64'd0);
        chk("rst_ovf",   64'(o_overflow),      64'd0);
        i_async_rst_n = 1'b1;
        step();

        // Single word: two-edge latency then 7 consecutive beats
        bif.i_beat_rdy = 1'b1;
        push(56'h0123456789ABCD);
        chk("sw_level_t", 64'(o_level), 64'd1);
        chk("sw_vld_t",   64'(bif.o_beat_vld), 64'd0);
        step();
        for (int k = 0; k < 7; k++) begin
            chk("sw_vld",  64'(bif.o_beat_vld),  64'd1);
            chk("sw_data", 64'(bif.o_beat_data), 64'(beat_of(56'h0123456789ABCD, k)));
            chk("sw_last", 64'(bif.o_beat_last), 64'(k == 6));
            step();
        end
        chk("sw_vld_end",   64'(bif.o_beat_vld), 64'd0);
        chk("sw_level_end", 64'(o_level),        64'd0);

        // Back-to-back: three words, 21 gapless beats, level follows pushes and pops
        ws[0] = 56'hA0A1A2A3A4A5A6;
        ws[1] = 56'hB0B1B2B3B4B5B6;
        ws[2] = 56'hC0C1C2C3C4C5C6;
        i_vld  = 1'b1;
        i_data = ws[0];
        step();
        chk("bb_level0", 64'(o_level), 64'd1);
        i_data = ws[1];
        step();
        chk("bb_level1", 64'(o_level), 64'd1);
        chk("bb_beat0",  64'(bif.o_beat_data), 64'(beat_of(ws[0], 0)));
        i_data = ws[2];
        step();
        i_vld = 1'b0;
        for (int i = 1; i < 21; i++) begin
            chk("bb_vld",   64'(bif.o_beat_vld),  64'd1);
            chk("bb_data",  64'(bif.o_beat_data), 64'(beat_of(ws[i / 7], i % 7)));
            chk("bb_last",  64'(bif.o_beat_last), 64'(i % 7 == 6));
            chk("bb_level", 64'(o_level), (i <= 6) ? 64'd2 : (i <= 13) ? 64'd1 : 64'd0);
            step();
        end
        chk("bb_vld_end", 64'(bif.o_beat_vld), 64'd0);

        // Backpressure: ready toggles 1,0,0 and beats must hold while stalled
        push(56'h13579BDF02468A);
        recv_word(56'h13579BDF02468A, 1'b1, "bp");
        step();
        chk("bp_vld_end", 64'(bif.o_beat_vld), 64'd0);

        // Overflow: one word in the shift register, four fill the FIFO, sixth dropped
        bif.i_beat_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ws[i] = {7{8'(8'h20 + 8'(i))}};
            push(ws[i]);
        end
        chk("ov_full",   64'(o_full),     64'd1);
        chk("ov_level",  64'(o_level),    64'd4);
        chk("ov_ovf_pre", 64'(o_overflow), 64'd0);
        push(56'hDEADDEADDEADDE);
        chk("ov_ovf",    64'(o_overflow), 64'd1);
        chk("ov_level2", 64'(o_level),    64'd4);
        for (int i = 0; i < 5; i++) recv_word(ws[i], 1'b0, "ov_drain");
        repeat (3) step();
        chk("ov_vld_end",   64'(bif.o_beat_vld), 64'd0);
        chk("ov_level_end", 64'(o_level),        64'd0);
        i_clr_ovf = 1'b1;
        step();
        i_clr_ovf = 1'b0;
        chk("ov_clr_alone0", 64'(o_overflow), 64'd0);

        // Set wins over clear when both land on the same edge
        bif.i_beat_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ws[i] = {7{8'(8'h40 + 8'(i))}};
            push(ws[i]);
        end
        chk("ov2_full", 64'(o_full), 64'd1);
        i_clr_ovf = 1'b1;
        push(56'h0BADBADBADBAD0);
        i_clr_ovf = 1'b0;
        chk("ov_set_wins", 64'(o_overflow), 64'd1);
        i_clr_ovf = 1'b1;
        step();
        i_clr_ovf = 1'b0;
        chk("ov_clr_alone1", 64'(o_overflow), 64'd0);
        for (int i = 0; i < 5; i++) recv_word(ws[i], 1'b0, "ov2_drain");

        // Wrap-around: 10 words spaced 7 cycles apart, all must emerge in order
        bif.i_beat_rdy = 1'b1;
        sent = 0;
        got  = 0;
        kb   = 0;
        for (int c = 0; c < 150 && got < 10; c++) begin
            if (bif.o_beat_vld) begin
                if (wq.size() == 0) begin
                    chk("wrap_spurious", 64'd1, 64'd0);
                end else begin
                    chk("wrap_data", 64'(bif.o_beat_data), 64'(beat_of(wq[0], kb)));
                    if (kb == 6) begin
                        kb = 0;
                        void'(wq.pop_front());
                        got++;
                    end else begin
                        kb++;
                    end
                end
            end
            if (c % 7 == 0 && sent < 10) begin
                b      = 8'h60 + 8'(sent);
                i_vld  = 1'b1;
                i_data = {7{b}} ^ 56'h01020304050607;
                wq.push_back(i_data);
                sent++;
            end else begin
                i_vld = 1'b0;
            end
            step();
        end
        i_vld = 1'b0;
        chk("wrap_count", 64'(got), 64'd10);

        // Reset mid-word: beat 3 showing, two words queued
        repeat (3) step();
        push(56'h11111111111111);
        push(56'h22222222222222);
        push(56'h33333333333333);
        step();
        step();
        chk("mr_beat3_vld",   64'(bif.o_beat_vld), 64'd1);
        chk("mr_beat3_level", 64'(o_level),        64'd2);
        #2;
        i_async_rst_n = 1'b0;
        #1;
        chk("mr_vld",   64'(bif.o_beat_vld),  64'd0);
        chk("mr_data",  64'(bif.o_beat_data), 64'd0);
        chk("mr_last",  64'(bif.o_beat_last), 64'd0);
        chk("mr_full",  64'(o_full),          64'd0);
        chk("mr_level", 64'(o_level),         64'd0);
        chk("mr_ovf",   64'(o_overflow),      64'd0);
        step();
        i_async_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("mr_quiet_vld", 64'(bif.o_beat_vld), 64'd0);
            step();
        end
        chk("mr_quiet_level", 64'(o_level), 64'd0);
        push(56'h5A5A5A5AA5A5A5);
        recv_word(56'h5A5A5A5AA5A5A5, 1'b0, "mr_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
